// File: rtl/gate_vector_checker.sv
// Drives the four a/b operand combinations into an external set of seven basic
// gates and scores the returned results against a built-in truth model.
module gate_vector_checker #(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [6:0] gate_in,
  output logic       a,
  output logic       b,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [4:0] err_count,
  output logic [6:0] fail_mask,
  output logic [1:0] vec_idx
);

  localparam int unsigned CNT_W   = 4;
  localparam int unsigned GATES_W = 7;
  localparam int unsigned ERR_W   = 5;
  localparam int unsigned POP_W   = 3;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] APPLY = 2'd1;
  localparam logic [1:0] CHECK = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);

  logic [1:0]         state, state_d;
  logic [CNT_W-1:0]   settle_cnt, settle_cnt_d;
  logic [1:0]         vec_idx_d;
  logic               a_d, b_d, busy_d, done_d, pass_d;
  logic [ERR_W-1:0]   err_count_d;
  logic [GATES_W-1:0] fail_mask_d;

  logic [GATES_W-1:0] expected_c;
  logic [GATES_W-1:0] diff_c;
  logic [POP_W-1:0]   diff_pop_c;

  // Truth model and per-vector mismatch count from the registered operands
  always_comb begin
    expected_c = {~(a ^ b), a ^ b, ~(a | b), ~(a & b), ~a, a | b, a & b};
    diff_c     = gate_in ^ expected_c;
    diff_pop_c = '0;
    for (int i = 0; i < int'(GATES_W); i++) begin
      diff_pop_c = diff_pop_c + POP_W'(diff_c[i]);
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d      = state;
    settle_cnt_d = settle_cnt;
    vec_idx_d    = vec_idx;
    a_d          = a;
    b_d          = b;
    busy_d       = busy;
    done_d       = 1'b0;
    pass_d       = pass;
    err_count_d  = err_count;
    fail_mask_d  = fail_mask;

    case (state)
      IDLE: begin
        if (start) begin
          err_count_d  = '0;
          fail_mask_d  = '0;
          pass_d       = 1'b0;
          vec_idx_d    = 2'd0;
          a_d          = 1'b0;
          b_d          = 1'b0;
          busy_d       = 1'b1;
          settle_cnt_d = '0;
          state_d      = APPLY;
        end
      end
      APPLY: begin
        if (settle_cnt == SETTLE_LAST) begin
          settle_cnt_d = '0;
          state_d      = CHECK;
        end else begin
          settle_cnt_d = settle_cnt + CNT_W'(1);
        end
      end
      CHECK: begin
        err_count_d = err_count + ERR_W'(diff_pop_c);
        fail_mask_d = fail_mask | diff_c;
        if (vec_idx != 2'd3) begin
          vec_idx_d  = vec_idx + 2'd1;
          {a_d, b_d} = vec_idx + 2'd1;
          state_d    = APPLY;
        end else begin
          state_d = DONE;
        end
      end
      DONE: begin
        done_d    = 1'b1;
        busy_d    = 1'b0;
        pass_d    = (err_count == '0);
        vec_idx_d = 2'd0;
        a_d       = 1'b0;
        b_d       = 1'b0;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      settle_cnt <= '0;
      vec_idx    <= 2'd0;
      a          <= 1'b0;
      b          <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      err_count  <= '0;
      fail_mask  <= '0;
    end else begin
      state      <= state_d;
      settle_cnt <= settle_cnt_d;
      vec_idx    <= vec_idx_d;
      a          <= a_d;
      b          <= b_d;
      busy       <= busy_d;
      done       <= done_d;
      pass       <= pass_d;
      err_count  <= err_count_d;
      fail_mask  <= fail_mask_d;
    end
  end

endmodule

// File: tb/tb_gate_vector_checker.sv
// Directed bench: golden and faulty gate models, start re-pulse and mid-run reset.
module tb_gate_vector_checker;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [6:0] gate_in;
  logic       a, b, busy, done, pass;
  logic [4:0] err_count;
  logic [6:0] fail_mask;
  logic [1:0] vec_idx;

  int passes;
  int checks;
  int fault_mode;

  gate_vector_checker #(.SETTLE_CYCLES(2)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .gate_in(gate_in),
    .a(a), .b(b), .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .fail_mask(fail_mask), .vec_idx(vec_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Gate model under test: 0 golden, 1 and stuck at 0, 2 xor inverted, 3 all zero
  always_comb begin
    gate_in = {~(a ^ b), a ^ b, ~(a | b), ~(a & b), ~a, a | b, a & b};
    case (fault_mode)
      1: gate_in[0] = 1'b0;
      2: gate_in[5] = ~(a ^ b);
      3: gate_in = 7'b0;
      default: ;
    endcase
  end

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_ab"}, int'({a, b}), 0);
    check({tag, "_idx"}, int'(vec_idx), 0);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_done"}, int'(done), 0);
    check({tag, "_pass"}, int'(pass), 0);
    check({tag, "_err"}, int'(err_count), 0);
    check({tag, "_mask"}, int'(fail_mask), 0);
  endtask

  // One full run; start accepted at the first posedge after the call (edge 0)
  task automatic run(input string tag, input int mode, input int exp_err,
                     input int exp_mask, input int exp_pass, input bit repulse);
    int done_cyc;
    int done_pulses;
    fault_mode = mode;
    done_cyc = -1;
    done_pulses = 0;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    check({tag, "_busy_start"}, int'(busy), 1);
    check({tag, "_idx0"}, int'(vec_idx), 0);
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(posedge clk);
      @(negedge clk);
      if (repulse && cyc == 4) start = 1'b1;
      if (repulse && cyc == 5) start = 1'b0;
      if (cyc == 3 || cyc == 6 || cyc == 9 || cyc == 11)
        check({tag, "_idx_seq"}, int'(vec_idx), cyc / 3);
      if (cyc == 6 || cyc == 12)
        check({tag, "_ab_seq"}, int'({a, b}), cyc / 3 - (cyc == 12 ? 1 : 0));
      if (done) begin
        done_pulses++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      if (cyc == 13) begin
        check({tag, "_busy_end"}, int'(busy), 0);
        check({tag, "_ab_end"}, int'({a, b}), 0);
        check({tag, "_idx_end"}, int'(vec_idx), 0);
      end
    end
    check({tag, "_done_cycle"}, done_cyc, 13);
    check({tag, "_done_pulses"}, done_pulses, 1);
    check({tag, "_err"}, int'(err_count), exp_err);
    check({tag, "_mask"}, int'(fail_mask), exp_mask);
    check({tag, "_pass"}, int'(pass), exp_pass);
  endtask

  initial begin
    passes = 0;
    checks = 0;
    fault_mode = 0;
    start = 1'b0;
    rst_n = 1'b0;
    #1;
    check_reset_values("por");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_values("idle");

    run("golden", 0, 0, 'h00, 1, 1'b0);
    run("and_stuck0", 1, 1, 'h01, 0, 1'b0);

    // Results persist in IDLE
    repeat (5) @(negedge clk);
    check("hold_err", int'(err_count), 1);
    check("hold_mask", int'(fail_mask), 'h01);

    run("xor_inv", 2, 4, 'h20, 0, 1'b0);
    run("all_zero", 3, 14, 'h7F, 0, 1'b0);
    run("repulse", 0, 0, 'h00, 1, 1'b1);

    // Mid-run reset during CHECK of idx2 (cycle after edge 8)
    fault_mode = 3;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    check("pre_reset_idx", int'(vec_idx), 2);
    check("pre_reset_err", int'(err_count), 8);
    rst_n = 1'b0;
    #1;
    check_reset_values("midrst");
    begin
      int seen_done;
      seen_done = 0;
      repeat (3) begin
        @(negedge clk);
        if (done) seen_done++;
      end
      rst_n = 1'b1;
      repeat (15) begin
        @(negedge clk);
        if (done) seen_done++;
      end
      check("midrst_no_done", seen_done, 0);
    end
    check("midrst_busy", int'(busy), 0);

    run("after_reset", 0, 0, 'h00, 1, 1'b0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/gate_vector_checker.md
GATE_VECTOR_CHECKER -- requirements
Module: gate_vector_checker

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 2, legal range 1..15, giving the number of cycles a/b are held before outputs are sampled.
REQ-002 SHALL have port clk  input  1  single system clock; all state updates on the rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port start  input  1  run request, sampled on a clk edge.
REQ-005 SHALL have port gate_in  input  7  gate results under test, ordered {xnor,xor,nor,nand,not,or,and} (bit0 = and).
REQ-006 SHALL have port a  output  1  stimulus operand a, registered.
REQ-007 SHALL have port b  output  1  stimulus operand b, registered.
REQ-008 SHALL have port busy  output  1  high while a run is in progress.
REQ-009 SHALL have port done  output  1  single-cycle pulse at run end.
REQ-010 SHALL have port pass  output  1  run result; high iff the last run had zero mismatches.
REQ-011 SHALL have port err_count  output  5  total mismatching bits in the last or current run.
REQ-012 SHALL have port fail_mask  output  7  sticky per-gate failure flags; same bit order as gate_in.
REQ-013 SHALL have port vec_idx  output  2  index of the vector currently applied.

Function
REQ-014 SHALL implement FSM states IDLE, APPLY, CHECK and DONE.
REQ-015 SHALL apply vectors in order idx0 (a=0,b=0), idx1 (0,1), idx2 (1,0), idx3 (1,1); {a,b} SHALL equal vec_idx.
REQ-016 SHALL compute expected = {~(a^b), a^b, ~(a|b), ~(a&b), ~a, a|b, a&b} from the registered a/b.
REQ-017 IDLE: when start=1, SHALL on that edge clear err_count, fail_mask and pass, set vec_idx=0, a=0, b=0, busy=1, and go to APPLY.
REQ-018 APPLY: SHALL hold for exactly SETTLE_CYCLES cycles, using an internal 4-bit counter, then go to CHECK.
REQ-019 CHECK (1 cycle): SHALL sample gate_in, add popcount(gate_in ^ expected) to err_count, and OR (gate_in ^ expected) into fail_mask.
REQ-020 CHECK: if vec_idx<3, SHALL increment vec_idx, update a/b and return to APPLY; if vec_idx=3, SHALL go to DONE.
REQ-021 Each vector SHALL therefore be held for SETTLE_CYCLES+1 cycles.
REQ-022 DONE (1 cycle): SHALL assert done=1, busy=0 and pass=(err_count==0), then go to IDLE.
REQ-023 After DONE, a/b SHALL return to 0 and vec_idx to 0.
REQ-024 done SHALL rise 4*(SETTLE_CYCLES+1)+1 cycles after the start-accept edge.
REQ-025 start SHALL be ignored in APPLY, CHECK and DONE; there is no queuing.
REQ-026 err_count, fail_mask and pass SHALL hold their values in IDLE until the next accepted start.
REQ-027 err_count SHALL NOT wrap; the maximum reachable value is 28.
REQ-028 Behaviour with SETTLE_CYCLES outside 1..15 SHALL be undefined; the block is not required to detect it.

Reset
REQ-029 While rst_n=0, independent of clk: state=IDLE, a=0, b=0, vec_idx=0, busy=0, done=0, pass=0, err_count=0, fail_mask=0, settle counter=0.
REQ-030 Reset asserted mid-run SHALL abort the run immediately with no done pulse.
REQ-031 After rst_n deasserts, the first accepted start SHALL begin a clean run.

Verification
REQ-032 Golden gate model connected, SETTLE_CYCLES=2, start pulse -> a/b sequence 00,01,10,11 with 3 cycles each; done at start+13; pass=1, err_count=0, fail_mask=0.
REQ-033 gate_in[0] (and) stuck at 0 -> err_count=1, fail_mask=7'b0000001, pass=0; the mismatch is recorded at idx3.
REQ-034 xor output inverted -> err_count=4, fail_mask=7'b0100000, pass=0.
REQ-035 gate_in tied to 7'b0 -> err_count=14, fail_mask=7'h7F, pass=0.
REQ-036 start re-pulsed during APPLY of idx1 -> ignored; done still at the original start+13; exactly one done pulse.
REQ-037 rst_n pulsed low during CHECK of idx2 -> all outputs at reset values immediately; no done; a fresh start then yields a correct full run.
